// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states
// and the lane/extension helpers used by the datapath.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Unsigned variants exist only for loads; alignment follows access size.
    function automatic logic req_is_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = a[0];
            F3_W:    err = (a != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | a[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << a;
            F3_H:    be = a[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wd[7:0]}};
            F3_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (a)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    d = {{24{b[7]}}, b};
            F3_BU:   d = {24'h000000, b};
            F3_H:    d = {{16{h[15]}}, h};
            F3_HU:   d = {16'h0000, h};
            F3_W:    d = word;
            default: d = 32'h00000000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus between the pipeline and the load/store unit.
interface lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/load_store_unit_data_ram.sv
// Word RAM with per-byte write enables and a registered read port.
module data_ram #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Single access port: byte-lane write or full-word read.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/load_store_unit.sv
// RV32I data-side memory stage: accepts one load/store at a time, accesses the
// internal RAM after MEM_LATENCY wait cycles and returns a one-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AL_W  = IDX_W + 2;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    lsu_state_t             r_state;
    logic                   r_we;
    logic [2:0]             r_funct3;
    logic [AL_W-1:0]        r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_rsp_valid;
    logic                   r_rsp_err;
    logic                   r_rsp_load;
    logic                   r_busy;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_req_err;
    logic                   w_ram_en;
    logic                   w_ram_we;
    logic [2:0]             w_ram_f3;
    logic [AL_W-1:0]        w_ram_addr;
    logic [DATA_WIDTH-1:0]  w_ram_wdata;
    logic [DATA_WIDTH-1:0]  w_ram_rdata;
    logic                   w_unused_addr;

    assign w_ready       = (r_state == IDLE) && !rst;
    assign w_accept      = bus.req_valid && w_ready;
    assign w_req_err     = req_is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign w_unused_addr = ^bus.req_addr[ADDR_WIDTH-1:AL_W];

    // RAM port source: live request for zero-latency access, latched request otherwise.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = r_we;
        w_ram_f3    = r_funct3;
        w_ram_addr  = r_addr;
        w_ram_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_ram_en    = w_accept && !w_req_err && (MEM_LATENCY == 0);
            w_ram_we    = bus.req_we;
            w_ram_f3    = bus.req_funct3;
            w_ram_addr  = bus.req_addr[AL_W-1:0];
            w_ram_wdata = bus.req_wdata;
        end else if (r_state == WAIT) begin
            w_ram_en = (r_cnt == {CNT_W{1'b0}});
        end else begin
            w_ram_en = 1'b0;
        end
    end

    data_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_be    (byte_enable(w_ram_f3, w_ram_addr[1:0])),
        .i_idx   (w_ram_addr[AL_W-1:2]),
        .i_wdata (store_data(w_ram_f3, w_ram_wdata)),
        .o_rdata (w_ram_rdata)
    );

    // Request FSM with registered response flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= {AL_W{1'b0}};
            r_wdata     <= {DATA_WIDTH{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_load  <= 1'b0;
                    if (w_accept) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr[AL_W-1:0];
                        r_wdata  <= bus.req_wdata;
                        r_busy   <= 1'b1;
                        if (w_req_err) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (MEM_LATENCY == 0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_load  <= !bus.req_we;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_W'(MEM_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_load  <= !r_we;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_load  <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_load  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Read data only leaves the unit alongside a successful load response.
    assign bus.rsp_rdata = r_rsp_load ? load_extend(r_funct3, r_addr[1:0], w_ram_rdata)
                                      : {DATA_WIDTH{1'b0}};
    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with MEM_LATENCY=2.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   a0;

    lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    load_store_unit #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (1024),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: every response pops the oldest expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, " rdata"}, bus.rsp_rdata, e.rdata);
                check({e.name, " err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
                check({e.name, " latency"}, cyc, e.due);
            end
        end
    end

    task automatic send(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input bit track);
        int budget;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        budget = 0;
        while (bus.req_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s accept: got req_ready=0 for 20 cycles, expected 1", nm);
        end else begin
            last_acc = cyc + 1;
            if (track) exp_q.push_back('{exp_rd, exp_err, cyc + (exp_err ? 1 : LAT + 1), nm});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        bus.req_valid = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        #3;
        check("reset req_ready", {31'b0, bus.req_ready}, 32'h0);
        check("reset busy", {31'b0, bus.busy}, 32'h0);
        check("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("release busy", {31'b0, bus.busy}, 32'h0);
        @(negedge clk);

        send("sw_100",   1'b1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1);
        send("lw_100",   1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
        send("sb_101",   1'b1, F3_B,  32'h101, 32'h00000080, 32'h0,        1'b0, 1'b1);
        send("lb_101",   1'b0, F3_B,  32'h101, 32'h0,        32'hFFFFFF80, 1'b0, 1'b1);
        send("lbu_101",  1'b0, F3_BU, 32'h101, 32'h0,        32'h00000080, 1'b0, 1'b1);
        send("lw_100b",  1'b0, F3_W,  32'h100, 32'h0,        32'hDEAD80EF, 1'b0, 1'b1);
        send("lh_102",   1'b0, F3_H,  32'h102, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b1);
        send("lhu_102",  1'b0, F3_HU, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, 1'b1);
        send("lh_103",   1'b0, F3_H,  32'h103, 32'h0,        32'h0,        1'b1, 1'b1);
        send("sw_102",   1'b1, F3_W,  32'h102, 32'h12345678, 32'h0,        1'b1, 1'b1);
        send("lw_after", 1'b0, F3_W,  32'h100, 32'h0,        32'hDEAD80EF, 1'b0, 1'b1);
        send("ld_f3_011",1'b0, 3'b011,32'h100, 32'h0,        32'h0,        1'b1, 1'b1);
        send("st_f3_100",1'b1, F3_BU, 32'h100, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b1);
        send("sh_102",   1'b1, F3_H,  32'h102, 32'h00001234, 32'h0,        1'b0, 1'b1);
        send("lw_sh",    1'b0, F3_W,  32'h100, 32'h0,        32'h123480EF, 1'b0, 1'b1);
        send("lh_100",   1'b0, F3_H,  32'h100, 32'h0,        32'hFFFF80EF, 1'b0, 1'b1);
        send("lw_wrap",  1'b0, F3_W,  32'h1100,32'h0,        32'h123480EF, 1'b0, 1'b1);
        drain();

        // Back-to-back with req_valid held high.
        @(negedge clk);
        send("b2b_0", 1'b0, F3_W, 32'h100, 32'h0, 32'h123480EF, 1'b0, 1'b1);
        a0 = last_acc;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("b2b req_ready busy", {31'b0, bus.req_ready}, 32'h0);
            check("b2b busy high", {31'b0, bus.busy}, 32'h1);
        end
        @(negedge clk);
        check("b2b req_ready idle", {31'b0, bus.req_ready}, 32'h1);
        check("b2b busy idle", {31'b0, bus.busy}, 32'h0);
        send("b2b_1", 1'b0, F3_W, 32'h100, 32'h0, 32'h123480EF, 1'b0, 1'b1);
        check("b2b accept gap", last_acc - a0, 32'd4);
        drain();

        // Store aborted by reset during WAIT.
        @(negedge clk);
        send("sw_drop", 1'b1, F3_W, 32'h200, 32'h00000055, 32'h0, 1'b0, 1'b0);
        bus.req_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("midrst busy", {31'b0, bus.busy}, 32'h0);
        check("midrst req_ready", {31'b0, bus.req_ready}, 32'h0);
        check("midrst rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("post_rst busy", {31'b0, bus.busy}, 32'h0);
        repeat (5) @(negedge clk);
        send("lw_200", 1'b0, F3_W, 32'h200, 32'h0, 32'h00000000, 1'b0, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
